// File: rtl/pc_gen_stage.sv
// pc_gen_stage: next-PC generation stage feeding a synchronous-read
// instruction SRAM. It owns the fetch PC and handles stall hold, branch
// redirect, a branch redirect that arrives during a stall, exception
// vectoring and ERET return.
// Optional build macro: ADDR_ALIGN_CHECK_EN enables the misaligned-fetch
// flag and forces SRAM address bits [1:0] to zero.
module pc_gen_stage #(
    parameter logic [31:0] RESET_PC   = 32'hbfc00000,
    parameter logic [31:0] EXC_VECTOR = 32'hbfc00380
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        exception,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic        inst_sram_en,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_raddr,
    output logic        pc_valid,
    output logic        redir_pending,
    output logic        fetch_adel
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_stateNext;
    logic [31:0] r_pc;
    logic        r_valid;
    logic        r_boot;
    logic [31:0] r_pendTgt;
    logic [31:0] w_pendTgtNext;
    logic [31:0] w_nextPc;

    // Next fetch address, highest-priority redirect first; the boot flag
    // makes the first post-reset fetch read RESET_PC itself.
    always_comb begin
        w_nextPc = r_pc + 32'd4;
        if (!resetn) begin
            w_nextPc = RESET_PC;
        end else if (exception) begin
            w_nextPc = EXC_VECTOR;
        end else if (eret) begin
            w_nextPc = epc;
        end else if (stall) begin
            w_nextPc = r_pc;
        end else if (br_taken) begin
            w_nextPc = br_target;
        end else if (r_state == HOLD) begin
            w_nextPc = r_pendTgt;
        end else if (r_boot) begin
            w_nextPc = RESET_PC;
        end
    end

    // Pending-redirect next state: a taken branch seen under stall is parked
    // until the stall lifts; exception/eret throw the parked target away.
    always_comb begin
        w_stateNext   = r_state;
        w_pendTgtNext = r_pendTgt;
        if (exception || eret) begin
            w_stateNext   = RUN;
            w_pendTgtNext = 32'd0;
        end else if (stall) begin
            if (br_taken) begin
                w_stateNext   = HOLD;
                w_pendTgtNext = br_target;
            end
        end else begin
            w_stateNext = RUN;
        end
    end

    // PC, valid, boot flag and pending-redirect registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_pc      <= RESET_PC;
            r_valid   <= 1'b0;
            r_boot    <= 1'b1;
            r_state   <= RUN;
            r_pendTgt <= 32'd0;
        end else begin
            r_pc      <= w_nextPc;
            r_valid   <= ~(exception | eret);
            r_boot    <= 1'b0;
            r_state   <= w_stateNext;
            r_pendTgt <= w_pendTgtNext;
        end
    end

    assign inst_sram_en    = resetn;
    assign inst_sram_raddr = r_pc;
    assign pc_valid        = r_valid;
    assign redir_pending   = (r_state == HOLD);

`ifdef ADDR_ALIGN_CHECK_EN
    assign inst_sram_addr = {w_nextPc[31:2], 2'b00};
    assign fetch_adel     = r_valid & (r_pc[1:0] != 2'b00);
`else
    assign inst_sram_addr = w_nextPc;
    assign fetch_adel     = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen_stage.sv
// tb_pc_gen_stage: scenario tasks drive one vector per cycle; the expected
// post-edge state is queued when a vector is driven and popped after the edge.
module tb_pc_gen_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        exception;
    logic        eret;
    logic [31:0] epc;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_raddr;
    logic        pc_valid;
    logic        redir_pending;
    logic        fetch_adel;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        exc;
        logic        eret;
        logic [31:0] epc;
        logic [31:0] sram;
        logic [31:0] raddr;
        logic        valid;
        logic        pend;
        logic        adel;
    } row_t;

    row_t expQ[$];

    pc_gen_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .stall           (stall),
        .br_taken        (br_taken),
        .br_target       (br_target),
        .exception       (exception),
        .eret            (eret),
        .epc             (epc),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_raddr (inst_sram_raddr),
        .pc_valid        (pc_valid),
        .redir_pending   (redir_pending),
        .fetch_adel      (fetch_adel)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic test_reset();
        row_t rows [0:2];
        row_t e;
        rows = '{
            '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'hbfc00000, 32'hbfc00000, 1'b1, 1'b0, 1'b0},
            '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'hbfc00004, 32'hbfc00004, 1'b1, 1'b0, 1'b0},
            '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'hbfc00008, 32'hbfc00008, 1'b1, 1'b0, 1'b0}
        };
        resetn = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = 32'h0;
        exception = 1'b0; eret = 1'b0; epc = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({inst_sram_en, inst_sram_addr, inst_sram_raddr, pc_valid, redir_pending, fetch_adel}
            !== {1'b0, 32'hbfc00000, 32'hbfc00000, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got en=%b addr=%h raddr=%h v=%b p=%b adel=%b, expected en=0 addr=bfc00000 raddr=bfc00000 v=0 p=0 adel=0",
                     inst_sram_en, inst_sram_addr, inst_sram_raddr, pc_valid, redir_pending, fetch_adel);
        end
        resetn = 1'b1;
        #1;
        vectors++;
        if ({inst_sram_en, pc_valid} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL reset_release: got en=%b v=%b, expected en=1 v=0", inst_sram_en, pc_valid);
        end
        foreach (rows[i]) begin
            vectors++;
            if (inst_sram_addr !== rows[i].sram) begin
                miscompares++;
                $display("[TB] FAIL reset_sram_addr row %0d: got %h expected %h", i, inst_sram_addr, rows[i].sram);
            end
            expQ.push_back(rows[i]);
            @(posedge clk); @(negedge clk); #1;
            e = expQ.pop_front();
            vectors++;
            if ({inst_sram_raddr, pc_valid, redir_pending, fetch_adel} !== {e.raddr, e.valid, e.pend, e.adel}) begin
                miscompares++;
                $display("[TB] FAIL reset_seq row %0d: got raddr=%h v=%b p=%b adel=%b, expected raddr=%h v=%b p=%b adel=%b",
                         i, inst_sram_raddr, pc_valid, redir_pending, fetch_adel, e.raddr, e.valid, e.pend, e.adel);
            end
        end
    endtask

    // Shared loop body is written per scenario so every task owns its checks.
    task automatic test_stall_branch();
        row_t rows [0:8];
        row_t e;
        rows = '{
            '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0, 32'hbfc00008, 32'hbfc00008, 1'b1, 1'b0, 1'b0},
            '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0, 32'hbfc00008, 32'hbfc00008, 1'b1, 1'b0, 1'b0},
            '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0, 32'hbfc0000c, 32'hbfc0000c, 1'b1, 1'b0, 1'b0},
            '{1'b0, 1'b1, 32'hbfc00100,  1'b0, 1'b0, 32'h0, 32'hbfc00100, 32'hbfc00100, 1'b1, 1'b0, 1'b0},
            '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0, 32'hbfc00104, 32'hbfc00104, 1'b1, 1'b0, 1'b0},
            '{1'b1, 1'b1, 32'hbfc00200,  1'b0, 1'b0, 32'h0, 32'hbfc00104, 32'hbfc00104, 1'b1, 1'b1, 1'b0},
            '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0, 32'hbfc00104, 32'hbfc00104, 1'b1, 1'b1, 1'b0},
            '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0, 32'hbfc00104, 32'hbfc00104, 1'b1, 1'b1, 1'b0},
            '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0, 32'hbfc00200, 32'hbfc00200, 1'b1, 1'b0, 1'b0}
        };
        foreach (rows[i]) begin
            stall = rows[i].stall; br_taken = rows[i].br; br_target = rows[i].tgt;
            exception = rows[i].exc; eret = rows[i].eret; epc = rows[i].epc;
            #1;
            vectors++;
            if (inst_sram_addr !== rows[i].sram) begin
                miscompares++;
                $display("[TB] FAIL stall_branch sram_addr row %0d: got %h expected %h", i, inst_sram_addr, rows[i].sram);
            end
            expQ.push_back(rows[i]);
            @(posedge clk); @(negedge clk);
            e = expQ.pop_front();
            vectors++;
            if ({inst_sram_raddr, pc_valid, redir_pending, fetch_adel} !== {e.raddr, e.valid, e.pend, e.adel}) begin
                miscompares++;
                $display("[TB] FAIL stall_branch row %0d: got raddr=%h v=%b p=%b adel=%b, expected raddr=%h v=%b p=%b adel=%b",
                         i, inst_sram_raddr, pc_valid, redir_pending, fetch_adel, e.raddr, e.valid, e.pend, e.adel);
            end
        end
    endtask

    task automatic test_back_to_back();
        row_t rows [0:7];
        row_t e;
        rows = '{
            '{1'b1, 1'b1, 32'hbfc00300, 1'b0, 1'b0, 32'h0, 32'hbfc00200, 32'hbfc00200, 1'b1, 1'b1, 1'b0},
            '{1'b1, 1'b1, 32'hbfc00400, 1'b0, 1'b0, 32'h0, 32'hbfc00200, 32'hbfc00200, 1'b1, 1'b1, 1'b0},
            '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0, 32'hbfc00400, 32'hbfc00400, 1'b1, 1'b0, 1'b0},
            '{1'b1, 1'b1, 32'hbfc00500, 1'b0, 1'b0, 32'h0, 32'hbfc00400, 32'hbfc00400, 1'b1, 1'b1, 1'b0},
            '{1'b0, 1'b1, 32'hbfc00600, 1'b0, 1'b0, 32'h0, 32'hbfc00600, 32'hbfc00600, 1'b1, 1'b0, 1'b0},
            '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0, 32'hbfc00604, 32'hbfc00604, 1'b1, 1'b0, 1'b0},
            '{1'b0, 1'b1, 32'hfffffffc, 1'b0, 1'b0, 32'h0, 32'hfffffffc, 32'hfffffffc, 1'b1, 1'b0, 1'b0},
            '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0}
        };
        foreach (rows[i]) begin
            stall = rows[i].stall; br_taken = rows[i].br; br_target = rows[i].tgt;
            exception = rows[i].exc; eret = rows[i].eret; epc = rows[i].epc;
            #1;
            vectors++;
            if (inst_sram_addr !== rows[i].sram) begin
                miscompares++;
                $display("[TB] FAIL back_to_back sram_addr row %0d: got %h expected %h", i, inst_sram_addr, rows[i].sram);
            end
            expQ.push_back(rows[i]);
            @(posedge clk); @(negedge clk);
            e = expQ.pop_front();
            vectors++;
            if ({inst_sram_raddr, pc_valid, redir_pending, fetch_adel} !== {e.raddr, e.valid, e.pend, e.adel}) begin
                miscompares++;
                $display("[TB] FAIL back_to_back row %0d: got raddr=%h v=%b p=%b adel=%b, expected raddr=%h v=%b p=%b adel=%b",
                         i, inst_sram_raddr, pc_valid, redir_pending, fetch_adel, e.raddr, e.valid, e.pend, e.adel);
            end
        end
    endtask

    task automatic test_exception();
        row_t rows [0:9];
        row_t e;
        rows = '{
            '{1'b1, 1'b1, 32'hbfc00700, 1'b0, 1'b0, 32'h0,        32'h00000000, 32'h00000000, 1'b1, 1'b1, 1'b0},
            '{1'b1, 1'b1, 32'hbfc00800, 1'b1, 1'b1, 32'hbfc00010, 32'hbfc00380, 32'hbfc00380, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'hbfc00384, 32'hbfc00384, 1'b1, 1'b0, 1'b0},
            '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'hbfc00010, 32'hbfc00010, 32'hbfc00010, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'hbfc00014, 32'hbfc00014, 1'b1, 1'b0, 1'b0},
            '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'hbfc00020, 32'hbfc00020, 32'hbfc00020, 1'b0, 1'b0, 1'b0},
            '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'hbfc00024, 32'hbfc00024, 1'b1, 1'b0, 1'b0},
            '{1'b0, 1'b1, 32'hbfc00900, 1'b1, 1'b0, 32'h0,        32'hbfc00380, 32'hbfc00380, 1'b0, 1'b0, 1'b0},
            '{1'b1, 1'b1, 32'hbfc00a00, 1'b0, 1'b0, 32'h0,        32'hbfc00380, 32'hbfc00380, 1'b1, 1'b1, 1'b0},
            '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'hbfc00040, 32'hbfc00040, 32'hbfc00040, 1'b0, 1'b0, 1'b0}
        };
        foreach (rows[i]) begin
            stall = rows[i].stall; br_taken = rows[i].br; br_target = rows[i].tgt;
            exception = rows[i].exc; eret = rows[i].eret; epc = rows[i].epc;
            #1;
            vectors++;
            if (inst_sram_addr !== rows[i].sram) begin
                miscompares++;
                $display("[TB] FAIL exception sram_addr row %0d: got %h expected %h", i, inst_sram_addr, rows[i].sram);
            end
            expQ.push_back(rows[i]);
            @(posedge clk); @(negedge clk);
            e = expQ.pop_front();
            vectors++;
            if ({inst_sram_raddr, pc_valid, redir_pending, fetch_adel} !== {e.raddr, e.valid, e.pend, e.adel}) begin
                miscompares++;
                $display("[TB] FAIL exception row %0d: got raddr=%h v=%b p=%b adel=%b, expected raddr=%h v=%b p=%b adel=%b",
                         i, inst_sram_raddr, pc_valid, redir_pending, fetch_adel, e.raddr, e.valid, e.pend, e.adel);
            end
        end
    endtask

    task automatic test_align();
        row_t rows [0:2];
        row_t e;
        logic [31:0] misSram;
        logic        misAdel;
`ifdef ADDR_ALIGN_CHECK_EN
        misSram = 32'hbfc00100;
        misAdel = 1'b1;
`else
        misSram = 32'hbfc00102;
        misAdel = 1'b0;
`endif
        rows = '{
            '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0, 32'hbfc00044, 32'hbfc00044, 1'b1, 1'b0, 1'b0},
            '{1'b0, 1'b1, 32'hbfc00102, 1'b0, 1'b0, 32'h0, misSram,      32'hbfc00102, 1'b1, 1'b0, misAdel},
            '{1'b0, 1'b1, 32'hbfc00110, 1'b0, 1'b0, 32'h0, 32'hbfc00110, 32'hbfc00110, 1'b1, 1'b0, 1'b0}
        };
        foreach (rows[i]) begin
            stall = rows[i].stall; br_taken = rows[i].br; br_target = rows[i].tgt;
            exception = rows[i].exc; eret = rows[i].eret; epc = rows[i].epc;
            #1;
            vectors++;
            if (inst_sram_addr !== rows[i].sram) begin
                miscompares++;
                $display("[TB] FAIL align sram_addr row %0d: got %h expected %h", i, inst_sram_addr, rows[i].sram);
            end
            expQ.push_back(rows[i]);
            @(posedge clk); @(negedge clk);
            e = expQ.pop_front();
            vectors++;
            if ({inst_sram_raddr, pc_valid, redir_pending, fetch_adel} !== {e.raddr, e.valid, e.pend, e.adel}) begin
                miscompares++;
                $display("[TB] FAIL align row %0d: got raddr=%h v=%b p=%b adel=%b, expected raddr=%h v=%b p=%b adel=%b",
                         i, inst_sram_raddr, pc_valid, redir_pending, fetch_adel, e.raddr, e.valid, e.pend, e.adel);
            end
        end
        br_taken = 1'b0;
    endtask

    // Scenario sequence; each task leaves the DUT at the PC the next expects.
    initial begin
        test_reset();
        test_stall_branch();
        test_back_to_back();
        test_exception();
        test_align();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
